// File: rtl/uart_tx.sv
// UART transmitter: one byte per request, 8 data bits LSB first,
// optional even/odd parity, one or two stop bits, internal baud divider.
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TX_START,
    input  logic [7:0] Tx_Byte,
    output logic       SO,
    output logic       TX_BUSY,
    output logic       TX_DONE
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CPB - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    shift, shift_d;
    logic          par_bit, par_d;
    logic          so_d, busy_d, done_d;
    logic          tick;
    logic          last_stop;
    logic          load;

    assign tick      = (baud_cnt == BAUD_MAX);
    assign last_stop = (state == S_STOP) && tick && (bit_cnt == LAST_STOP);
    assign load      = TX_START && ((state == S_IDLE) || last_stop);

    // State and registered outputs; SO only ever comes from this flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            SO       <= 1'b1;
            TX_BUSY  <= 1'b0;
            TX_DONE  <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            par_bit  <= par_d;
            SO       <= so_d;
            TX_BUSY  <= busy_d;
            TX_DONE  <= done_d;
        end
    end

    // Next-state logic; a new byte may be loaded on the last stop edge
    // so consecutive frames follow each other with no idle gap.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        par_d   = par_bit;
        so_d    = SO;
        busy_d  = TX_BUSY;
        done_d  = 1'b0;

        unique case (state)
            S_IDLE: begin
                so_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
            end
            S_START: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    so_d    = shift[0];
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            so_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            so_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_cnt + 3'd1;
                        shift_d = {1'b0, shift[7:1]};
                        so_d    = shift[1];
                    end
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                    so_d    = 1'b1;
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            S_STOP: begin
                so_d = 1'b1;
                if (tick) begin
                    baud_d = '0;
                    if (bit_cnt == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                so_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            shift_d = Tx_Byte;
            par_d   = (PARITY == 2) ? ~^Tx_Byte : ^Tx_Byte;
            state_d = S_START;
            so_d    = 1'b0;
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, 8E1, 8O1, 8N2
// at 10 clocks per bit; SO is sampled mid-bit and decoded.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [3:0] start = 4'h0;
    wire  [3:0] so;
    wire  [3:0] busy;
    wire  [3:0] done;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] bits;
    int          busy_len, ndone, first_done, last_done, low_cnt;
    logic        so_fd;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .CLK(clk), .RST_N(rst_n), .TX_START(start[0]), .Tx_Byte(tx_byte),
        .SO(so[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0]));
    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .CLK(clk), .RST_N(rst_n), .TX_START(start[1]), .Tx_Byte(tx_byte),
        .SO(so[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1]));
    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .CLK(clk), .RST_N(rst_n), .TX_START(start[2]), .Tx_Byte(tx_byte),
        .SO(so[2]), .TX_BUSY(busy[2]), .TX_DONE(done[2]));
    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .CLK(clk), .RST_N(rst_n), .TX_START(start[3]), .Tx_Byte(tx_byte),
        .SO(so[3]), .TX_BUSY(busy[3]), .TX_DONE(done[3]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        tx_byte = b;
        start[idx] = 1'b1;
        tick();
        start[idx] = 1'b0;
    endtask

    // Runs maxc cycles after the accept edge, sampling SO mid-bit.
    // Optionally raises TX_START with inj_byte at edges inj_c..inj_c+inj_len-1.
    task automatic run_frame(input int idx, input int maxc, input int inj_c,
                             input int inj_len, input logic [7:0] inj_byte,
                             output logic [23:0] b, output int blen,
                             output int nd, output int fd, output int ld,
                             output int lo, output logic sfd);
        b = '1;
        blen = 0;
        nd = 0;
        fd = 0;
        ld = 0;
        lo = (so[idx] == 1'b0) ? 1 : 0;
        sfd = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            if (inj_c > 0 && c == inj_c) begin
                tx_byte = inj_byte;
                start[idx] = 1'b1;
            end
            if (inj_c > 0 && c == inj_c + inj_len) start[idx] = 1'b0;
            tick();
            if ((c % 10) == 5 && (c / 10) < 24) b[c/10] = so[idx];
            if (so[idx] == 1'b0) lo++;
            if (!busy[idx] && blen == 0) blen = c;
            if (done[idx]) begin
                nd++;
                if (fd == 0) begin
                    fd = c;
                    sfd = so[idx];
                end
                ld = c;
            end
        end
        start[idx] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_so", {28'h0, so}, 32'hF);
        chk("rst_busy", {28'h0, busy}, 32'h0);
        chk("rst_done", {28'h0, done}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 8N1 frame of A5
        send(0, 8'hA5);
        chk("a5_so_accept", {31'h0, so[0]}, 32'h0);
        chk("a5_busy_accept", {31'h0, busy[0]}, 32'h1);
        run_frame(0, 130, 0, 0, 8'h00, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("a5_bits", {22'h0, bits[9:0]}, 32'h34A);
        chk("a5_busy_len", busy_len, 100);
        chk("a5_ndone", ndone, 1);
        chk("a5_done_at", first_done, 100);
        chk("a5_low_cycles", low_cnt, 50);
        chk("a5_so_at_done", {31'h0, so_fd}, 32'h1);

        // TX_START with 3C at clk 40 must be ignored
        send(0, 8'hA5);
        run_frame(0, 130, 40, 1, 8'h3C, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("ign_bits", {22'h0, bits[9:0]}, 32'h34A);
        chk("ign_ndone", ndone, 1);
        chk("ign_busy_len", busy_len, 100);

        // even parity, 07 -> parity 1
        send(1, 8'h07);
        run_frame(1, 130, 0, 0, 8'h00, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("even_bits", {21'h0, bits[10:0]}, 32'h60E);
        chk("even_busy_len", busy_len, 110);
        chk("even_done_at", first_done, 110);

        // odd parity, 07 -> parity 0
        send(2, 8'h07);
        run_frame(2, 130, 0, 0, 8'h00, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("odd_bits", {21'h0, bits[10:0]}, 32'h40E);
        chk("odd_busy_len", busy_len, 110);

        // two stop bits, 00
        send(3, 8'h00);
        run_frame(3, 130, 0, 0, 8'h00, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("stop2_bits", {21'h0, bits[10:0]}, 32'h600);
        chk("stop2_low_cycles", low_cnt, 90);
        chk("stop2_busy_len", busy_len, 110);
        chk("stop2_ndone", ndone, 1);

        // back-to-back: TX_START held high, 55 then FF
        send(0, 8'h55);
        run_frame(0, 230, 1, 149, 8'hFF, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("b2b_frame1", {22'h0, bits[9:0]}, 32'h2AA);
        chk("b2b_frame2", {22'h0, bits[19:10]}, 32'h3FE);
        chk("b2b_ndone", ndone, 2);
        chk("b2b_done1_at", first_done, 100);
        chk("b2b_done2_at", last_done, 200);
        chk("b2b_so_at_done1", {31'h0, so_fd}, 32'h0);
        chk("b2b_busy_len", busy_len, 200);

        // async reset mid-DATA aborts the frame
        send(0, 8'hA5);
        repeat (35) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_so", {31'h0, so[0]}, 32'h1);
        chk("arst_busy", {31'h0, busy[0]}, 32'h0);
        chk("arst_done", {31'h0, done[0]}, 32'h0);
        #2 rst_n = 1'b1;
        run_frame(0, 150, 0, 0, 8'h00, bits, busy_len, ndone, first_done, last_done, low_cnt, so_fd);
        chk("arst_no_done", ndone, 0);
        chk("arst_so_idle", low_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
